soc_pio_ctrl: RTL and testbench

SOC_PIO_CTRL -- requirements
Module: soc_pio_ctrl

---
 rtl/soc_pio_ctrl.sv | 154 +++++++++++++++
 tb/tb_soc_pio_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_pio_ctrl.sv
// soc_pio_ctrl: memory-mapped parallel I/O port.
// Provides an output data register with set/clear/toggle aliases, a per-bit
// direction register and a 2-flop input synchroniser.
// Optional macro PIO_EDGE_IRQ_EN adds rising-edge capture (EDGECAP), an
// interrupt mask (IRQMASK) and a registered level interrupt.
module soc_pio_ctrl #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_OUTTGL  = 3'd6;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] irqmask_rd;
  logic [WIDTH-1:0] edgecap_rd;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wd           = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Output data register: direct load plus set/clear/toggle aliases.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:   data_out <= wd;
        ADDR_OUTSET: data_out <= data_out | wd;
        ADDR_OUTCLR: data_out <= data_out & ~wd;
        ADDR_OUTTGL: data_out <= data_out ^ wd;
        default:     data_out <= data_out;
      endcase
    end
  end

  // Direction register (1 = drive the pin).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir <= '0;
    end else if (wr_en && address == ADDR_DIR) begin
      dir <= wd;
    end
  end

  // Two-flop synchroniser for the asynchronous pin inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  assign out_port = data_out;
  assign oe_port  = dir;

`ifdef PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] sync2_d;
  logic [WIDTH-1:0] rise;
  logic [2:0]       arm;

  // Delayed copy of sync2 plus arming shift register. Detection is held off
  // until sync2 and its delayed copy both carry post-release pin samples, so a
  // pin already high at reset release never looks like a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync2_d <= '0;
      arm     <= '0;
    end else begin
      sync2_d <= sync2;
      arm     <= {arm[1:0], 1'b1};
    end
  end

  assign rise = arm[2] ? (sync2 & ~sync2_d) : '0;

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr_en && address == ADDR_IRQMASK) begin
      irqmask <= wd;
    end
  end

  // Sticky edge capture; a new edge wins over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
    end else if (wr_en && address == ADDR_EDGECAP) begin
      edgecap <= (edgecap & ~wd) | rise;
    end else begin
      edgecap <= edgecap | rise;
    end
  end

  // Registered level interrupt from unmasked captured edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edgecap & irqmask);
    end
  end

  assign irqmask_rd = irqmask;
  assign edgecap_rd = edgecap;
`else
  assign irqmask_rd = '0;
  assign edgecap_rd = '0;
  assign irq        = 1'b0;
`endif

  // Combinational read mux; unused upper bits and write-only/reserved read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = sync2;
      ADDR_DIR:     readdata[WIDTH-1:0] = dir;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_rd;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_rd;
      default:      readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_pio_ctrl.sv
// Self-checking bench for soc_pio_ctrl (WIDTH=8, RESET_VALUE=8'hA5).
// Directed vector table, hand-written edge sequences and a randomized phase
// checked against a behavioural model.
module tb_soc_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  soc_pio_ctrl #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe_port(oe_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply a bus cycle at a negedge, advance through the next rising edge.
  task automatic tick(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    address = a; chipselect = cs; write_n = wn; writedata = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset (called at a negedge), check reset outputs before any clock.
  task automatic do_reset(input logic [7:0] pins);
    reset_n = 1'b0;
    address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    in_port = pins;
    #1;
    chk("rst_out", out_port, 8'hA5);
    chk("rst_oe", oe_port, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("rst_data", readdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_out, m_dir, m_mask, m_cap;
  logic       m_irq;
  logic [7:0] hist[$];  // pin values sampled at each rising edge since release

  function automatic void model_reset();
    m_out = 8'hA5; m_dir = '0; m_mask = '0; m_cap = '0; m_irq = 1'b0;
    hist.delete();
    hist.push_back(8'h00);
    hist.push_back(8'h00);
  endfunction

  // The readable DATA value is the pin value sampled two edges ago.
  function automatic logic [7:0] readable();
    return hist[hist.size()-2];
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {24'h0, readable()};
      3'd1: return {24'h0, m_dir};
`ifdef PIO_EDGE_IRQ_EN
      3'd2: return {24'h0, m_mask};
      3'd3: return {24'h0, m_cap};
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step(input logic [2:0] a, input logic cs, input logic wn,
                                     input logic [31:0] wd, input logic [7:0] pins);
    logic       wr;
    logic [7:0] d;
    logic [7:0] rise;
    int         n;
    wr   = cs & ~wn;
    d    = wd[7:0];
    n    = hist.size();
    rise = '0;
    // An edge only counts when both compared samples were taken after release.
    if (n - 3 >= 2) rise = hist[n-2] & ~hist[n-3];
`ifdef PIO_EDGE_IRQ_EN
    m_irq = |(m_cap & m_mask);
    if (wr && a == 3'd3) m_cap = (m_cap & ~d) | rise;
    else                 m_cap = m_cap | rise;
    if (wr && a == 3'd2) m_mask = d;
`endif
    if (wr) begin
      case (a)
        3'd0: m_out = d;
        3'd1: m_dir = d;
        3'd4: m_out = m_out | d;
        3'd5: m_out = m_out & ~d;
        3'd6: m_out = m_out ^ d;
        default: ;
      endcase
    end
    hist.push_back(pins);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  waddr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [2:0]  raddr;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'd0, 1'b1, 1'b0, 32'h0000_00F0, 3'd0, 8'hF0, 8'h00, 32'h0};
    vecs[1] = '{3'd4, 1'b1, 1'b0, 32'h0000_000F, 3'd4, 8'hFF, 8'h00, 32'h0};
    vecs[2] = '{3'd5, 1'b1, 1'b0, 32'h0000_0081, 3'd5, 8'h7E, 8'h00, 32'h0};
    vecs[3] = '{3'd6, 1'b1, 1'b0, 32'h0000_00FF, 3'd6, 8'h81, 8'h00, 32'h0};
    vecs[4] = '{3'd1, 1'b1, 1'b0, 32'h0000_003C, 3'd1, 8'h81, 8'h3C, 32'h0000_003C};
    vecs[5] = '{3'd0, 1'b0, 1'b0, 32'h0000_0000, 3'd0, 8'h81, 8'h3C, 32'h0};
    vecs[6] = '{3'd1, 1'b1, 1'b1, 32'h0000_0000, 3'd1, 8'h81, 8'h3C, 32'h0000_003C};
    vecs[7] = '{3'd7, 1'b1, 1'b0, 32'h0000_00FF, 3'd7, 8'h81, 8'h3C, 32'h0};
    vecs[8] = '{3'd1, 1'b1, 1'b0, 32'hFFFF_FF00, 3'd1, 8'h81, 8'h00, 32'h0};
    vecs[9] = '{3'd0, 1'b1, 1'b0, 32'hFFFF_FF5A, 3'd0, 8'h5A, 8'h00, 32'h0};

    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    @(negedge clk);

    // Reset values and 2-cycle pin-to-readable latency.
    do_reset(8'h00);
    tick(3'd0, 1'b0, 1'b1, 32'h0);
    tick(3'd0, 1'b0, 1'b1, 32'h0);
    chk("data_after_rst", readdata, 32'h0);
    in_port = 8'h5A;
    tick(3'd0, 1'b0, 1'b1, 32'h0);
    chk("sync_lat1", readdata, 32'h0);
    tick(3'd0, 1'b0, 1'b1, 32'h0);
    chk("sync_lat2", readdata, 32'h0000_005A);
    in_port = 8'h00;
    tick(3'd0, 1'b0, 1'b1, 32'h0);
    tick(3'd0, 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < 10; i++) begin
      tick(vecs[i].waddr, vecs[i].cs, vecs[i].wn, vecs[i].wd);
      chk($sformatf("vec%0d_out", i), out_port, vecs[i].exp_out);
      chk($sformatf("vec%0d_oe", i), oe_port, vecs[i].exp_oe);
      address = vecs[i].raddr; chipselect = 1'b0;
      #1;
      chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      @(negedge clk);
    end

`ifdef PIO_EDGE_IRQ_EN
    // Edge capture into an unmasked bit, interrupt, then clear.
    do_reset(8'h00);
    tick(3'd2, 1'b1, 1'b0, 32'h01);
    tick(3'd3, 1'b0, 1'b1, 32'h0);
    tick(3'd3, 1'b0, 1'b1, 32'h0);
    in_port = 8'h01;
    tick(3'd3, 1'b0, 1'b1, 32'h0);
    tick(3'd3, 1'b0, 1'b1, 32'h0);
    chk("cap_early", readdata, 32'h0);
    tick(3'd3, 1'b0, 1'b1, 32'h0);
    chk("cap_set", readdata, 32'h01);
    chk("irq_early", irq, 1'b0);
    tick(3'd3, 1'b0, 1'b1, 32'h0);
    chk("irq_set", irq, 1'b1);
    tick(3'd3, 1'b1, 1'b0, 32'h01);
    chk("cap_clr", readdata, 32'h0);
    tick(3'd3, 1'b0, 1'b1, 32'h0);
    chk("irq_clr", irq, 1'b0);

    // Pin high through release is not an edge; edge beats same-cycle clear.
    do_reset(8'h02);
    for (int i = 0; i < 6; i++) tick(3'd3, 1'b0, 1'b1, 32'h0);
    chk("no_rst_edge", readdata, 32'h0);
    in_port = 8'h06;
    for (int i = 0; i < 3; i++) tick(3'd3, 1'b0, 1'b1, 32'h0);
    chk("cap_bit2", readdata, 32'h04);
    in_port = 8'h02;
    for (int i = 0; i < 3; i++) tick(3'd3, 1'b0, 1'b1, 32'h0);
    in_port = 8'h06;
    tick(3'd3, 1'b0, 1'b1, 32'h0);
    tick(3'd3, 1'b0, 1'b1, 32'h0);
    tick(3'd3, 1'b1, 1'b0, 32'h04);
    chk("edge_beats_clr", readdata, 32'h04);
    tick(3'd3, 1'b1, 1'b0, 32'h04);
    chk("clr_bit2", readdata, 32'h0);
`else
    // Edge/IRQ logic absent: addresses 2, 3 and 7 read 0, irq stays low.
    do_reset(8'h00);
    tick(3'd2, 1'b1, 1'b0, 32'hFF);
    tick(3'd3, 1'b1, 1'b0, 32'hFF);
    for (int i = 0; i < 6; i++) begin
      in_port = (i % 2 == 0) ? 8'hFF : 8'h00;
      tick(3'd0, 1'b0, 1'b1, 32'h0);
    end
    chk("noirq_irq", irq, 1'b0);
    address = 3'd2; #1 chk("noirq_rd2", readdata, 32'h0);
    address = 3'd3; #1 chk("noirq_rd3", readdata, 32'h0);
    address = 3'd7; #1 chk("noirq_rd7", readdata, 32'h0);
    @(negedge clk);
`endif

    // Randomized phase against the model, with one mid-operation reset.
    do_reset(8'h00);
    model_reset();
    for (int i = 0; i < 600; i++) begin
      logic [2:0]  a;
      logic        cs, wn;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      address = a; chipselect = cs; write_n = wn; writedata = wd;
      #1;
      chk("rand_rd", readdata, model_read(a));
      @(posedge clk);
      model_step(a, cs, wn, wd, in_port);
      @(negedge clk);
      chk("rand_out", out_port, m_out);
      chk("rand_oe", oe_port, m_dir);
      chk("rand_irq", irq, m_irq);
      if (i == 300) begin
        do_reset(in_port);
        model_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
